// File: rtl/avl_uart_bus_arbiter.sv
// ---------------------------------------------------------------------------
// avl_uart_bus_arbiter
//
// Purpose:
//   Two-requester Avalon-MM master arbiter in front of avl_uart_interface.
//   A TX producer and an RX/status poller share one UART Avalon slave port.
//   Arbitration is round-robin and only one Avalon transfer is outstanding at
//   a time. Reads that never see readdatavalid are aborted after RD_TIMEOUT
//   cycles in WAIT_RD.
//
// Ports:
//   avl_clk_i            clock, all logic on rising edge
//   avl_reset_i          synchronous active-high reset
//   req_valid_i[1:0]     per-requester command valid (bit i = requester i)
//   req_write_i[1:0]     1 = write, 0 = read
//   req_address_i        packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_byteenable_i     packed byte enables
//   req_writedata_i      packed write data
//   req_ready_o[1:0]     command accepted this cycle (combinational, IDLE only)
//   req_done_o[1:0]      one-cycle pulse: write accepted or read data returned
//   req_err_o[1:0]       one-cycle pulse: read aborted by timeout
//   rdata_o              last successfully read data word
//   avl_*_o / avl_*_i    Avalon-MM master port toward the UART slave
// ---------------------------------------------------------------------------
module avl_uart_bus_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int RD_TIMEOUT = 1024
) (
  input  logic                        avl_clk_i,
  input  logic                        avl_reset_i,

  input  logic [1:0]                  req_valid_i,
  input  logic [1:0]                  req_write_i,
  input  logic [2*ADDR_WIDTH-1:0]     req_address_i,
  input  logic [2*(DATA_WIDTH/8)-1:0] req_byteenable_i,
  input  logic [2*DATA_WIDTH-1:0]     req_writedata_i,
  output logic [1:0]                  req_ready_o,
  output logic [1:0]                  req_done_o,
  output logic [1:0]                  req_err_o,
  output logic [DATA_WIDTH-1:0]       rdata_o,

  output logic [ADDR_WIDTH-1:0]       avl_address_o,
  output logic [DATA_WIDTH/8-1:0]     avl_byteenable_o,
  output logic                        avl_write_o,
  output logic [DATA_WIDTH-1:0]       avl_writedata_o,
  output logic                        avl_read_o,
  input  logic                        avl_waitrequest_i,
  input  logic                        avl_readdatavalid_i,
  input  logic [DATA_WIDTH-1:0]       avl_readdata_i
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int TMR_WIDTH = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(RD_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;

  // -------------------------------------------------------------------------
  // State and command registers
  // -------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic                  r_last_grant;
  logic                  r_grant;
  logic                  r_cmd_write;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [BE_WIDTH-1:0]   r_cmd_be;
  logic [DATA_WIDTH-1:0] r_cmd_wdata;
  logic                  r_avl_write;
  logic                  r_avl_read;
  logic [TMR_WIDTH-1:0]  r_timer;
  logic [1:0]            r_done;
  logic [1:0]            r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  // -------------------------------------------------------------------------
  // Per-requester views of the packed command buses
  // -------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] w_req_addr  [2];
  logic [BE_WIDTH-1:0]   w_req_be    [2];
  logic [DATA_WIDTH-1:0] w_req_wdata [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign w_req_addr[gi]  = req_address_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_req_be[gi]    = req_byteenable_i[gi*BE_WIDTH +: BE_WIDTH];
      assign w_req_wdata[gi] = req_writedata_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Grant selection. With both requesters valid the one that was not served
  // last wins, which yields strict alternation under continuous load.
  // -------------------------------------------------------------------------
  logic w_grant;
  logic w_accept;
  logic w_grant_write;

  always_comb begin
    w_grant = r_last_grant;
    case (req_valid_i)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = r_last_grant;
    endcase
  end

  assign w_accept      = (r_state == S_IDLE) && (|req_valid_i);
  assign w_grant_write = req_write_i[w_grant];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready_o[gi] = w_accept && (w_grant == 1'(gi));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Main FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge avl_clk_i) begin
    if (avl_reset_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cmd_write  <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_be     <= '0;
      r_cmd_wdata  <= '0;
      r_avl_write  <= 1'b0;
      r_avl_read   <= 1'b0;
      r_timer      <= '0;
      r_done       <= '0;
      r_err        <= '0;
      r_rdata      <= '0;
    end else begin
      // Completion flags are single-cycle pulses.
      r_done <= '0;
      r_err  <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_grant;
            r_grant      <= w_grant;
            r_cmd_write  <= w_grant_write;
            r_cmd_addr   <= w_req_addr[w_grant];
            r_cmd_be     <= w_req_be[w_grant];
            // Write data bus stays quiet during reads.
            r_cmd_wdata  <= w_grant_write ? w_req_wdata[w_grant] : '0;
            r_avl_write  <= w_grant_write;
            r_avl_read   <= ~w_grant_write;
            r_state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Everything on the bus is frozen while the slave stalls.
          if (!avl_waitrequest_i) begin
            r_avl_write <= 1'b0;
            r_avl_read  <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_be    <= '0;
            r_cmd_wdata <= '0;
            if (r_cmd_write) begin
              r_done[r_grant] <= 1'b1;
              r_state         <= S_IDLE;
            end else begin
              r_timer <= '0;
              r_state <= S_WAIT_RD;
            end
          end
        end

        S_WAIT_RD: begin
          // Data takes priority over a timeout expiring on the same edge.
          if (avl_readdatavalid_i) begin
            r_rdata         <= avl_readdata_i;
            r_done[r_grant] <= 1'b1;
            r_state         <= S_IDLE;
          end else if (r_timer == TMR_LAST) begin
            r_err[r_grant] <= 1'b1;
            r_state        <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign req_done_o       = r_done;
  assign req_err_o        = r_err;
  assign rdata_o          = r_rdata;
  assign avl_address_o    = r_cmd_addr;
  assign avl_byteenable_o = r_cmd_be;
  assign avl_writedata_o  = r_cmd_wdata;
  assign avl_write_o      = r_avl_write;
  assign avl_read_o       = r_avl_read;

endmodule

// File: tb/tb_avl_uart_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avl_uart_bus_arbiter
//
// Directed self-checking bench for avl_uart_bus_arbiter (RD_TIMEOUT = 16).
// Inputs are driven 1 time unit after the rising edge, outputs are sampled on
// the falling edge. Cycle numbers in comments count from the grant cycle.
// ---------------------------------------------------------------------------
module tb_avl_uart_bus_arbiter;

  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_write;
  logic [2*AW-1:0]   req_address;
  logic [2*BW-1:0]   req_be;
  logic [2*DW-1:0]   req_wdata;
  logic [1:0]        req_ready;
  logic [1:0]        req_done;
  logic [1:0]        req_err;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     avl_address;
  logic [BW-1:0]     avl_be;
  logic              avl_write;
  logic [DW-1:0]     avl_wdata;
  logic              avl_read;
  logic              avl_waitreq;
  logic              avl_rdv;
  logic [DW-1:0]     avl_rdata;

  int n_cmp;
  int n_err;

  avl_uart_bus_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_TIMEOUT (16)
  ) dut (
    .avl_clk_i           (clk),
    .avl_reset_i         (rst),
    .req_valid_i         (req_valid),
    .req_write_i         (req_write),
    .req_address_i       (req_address),
    .req_byteenable_i    (req_be),
    .req_writedata_i     (req_wdata),
    .req_ready_o         (req_ready),
    .req_done_o          (req_done),
    .req_err_o           (req_err),
    .rdata_o             (rdata),
    .avl_address_o       (avl_address),
    .avl_byteenable_o    (avl_be),
    .avl_write_o         (avl_write),
    .avl_writedata_o     (avl_wdata),
    .avl_read_o          (avl_read),
    .avl_waitrequest_i   (avl_waitreq),
    .avl_readdatavalid_i (avl_rdv),
    .avl_readdata_i      (avl_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [BW-1:0] b);
    req_write[r]           = wr;
    req_address[r*AW +: AW] = a;
    req_wdata[r*DW +: DW]   = d;
    req_be[r*BW +: BW]      = b;
  endtask

  function automatic logic [127:0] all_outs();
    return {38'd0, req_ready, req_done, req_err, rdata, avl_address, avl_be,
            avl_write, avl_wdata, avl_read};
  endfunction

  int            n_req [2];
  int            e;
  logic [1:0]    e_oh;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    rst         = 1'b1;
    req_valid   = '0;
    req_write   = '0;
    req_address = '0;
    req_be      = '0;
    req_wdata   = '0;
    avl_waitreq = 1'b0;
    avl_rdv     = 1'b0;
    avl_rdata   = '0;

    // ---------------- Reset state ----------------
    nxt(); nxt();
    smp();
    check("reset_outs", all_outs(), 128'd0);

    // ---------------- Test 1: single zero-wait write ----------------
    nxt(); rst = 1'b0;
    set_req(0, 1'b1, 14'h001, 32'h0000_00A5, 4'hF);
    req_valid = 2'b01;
    smp();
    check("t1_ready_c0", 128'(req_ready), 128'(2'b01));
    nxt(); req_valid = 2'b00;
    smp();
    check("t1_write_c1", 128'({avl_write, avl_read}), 128'(2'b10));
    check("t1_addr_c1",  128'(avl_address), 128'(14'h001));
    check("t1_wdata_c1", 128'(avl_wdata), 128'(32'h0000_00A5));
    check("t1_be_c1",    128'(avl_be), 128'(4'hF));
    check("t1_done_c1",  128'(req_done), 128'(2'b00));
    nxt(); smp();
    check("t1_done_c2",  128'(req_done), 128'(2'b01));
    check("t1_write_c2", 128'(avl_write), 128'(1'b0));
    check("t1_err_c2",   128'(req_err), 128'(2'b00));
    nxt(); smp();
    check("t1_done_c3",  128'(req_done), 128'(2'b00));

    // ---------------- Test 2: fairness, 4 writes each ----------------
    nxt(); rst = 1'b1;
    nxt(); rst = 1'b0;
    n_req[0] = 0;
    n_req[1] = 0;
    set_req(0, 1'b1, 14'h010, 32'hC000_0000, 4'hF);
    set_req(1, 1'b1, 14'h020, 32'hC000_0100, 4'hF);
    req_valid = 2'b11;
    smp();
    for (int k = 0; k < 8; k++) begin
      e      = k % 2;
      e_oh   = 2'(1 << e);
      e_addr = (e == 1) ? 14'h020 : 14'h010;
      e_data = 32'hC000_0000 | 32'(e << 8) | 32'(n_req[e]);
      check($sformatf("t2_ready_%0d", k), 128'(req_ready), 128'(e_oh));
      nxt();
      n_req[e]++;
      set_req(e, 1'b1, e_addr, 32'hC000_0000 | 32'(e << 8) | 32'(n_req[e]), 4'hF);
      if (n_req[e] == 4) req_valid[e] = 1'b0;
      smp();
      check($sformatf("t2_wr_%0d", k),    128'(avl_write), 128'(1'b1));
      check($sformatf("t2_addr_%0d", k),  128'(avl_address), 128'(e_addr));
      check($sformatf("t2_wdata_%0d", k), 128'(avl_wdata), 128'(e_data));
      nxt(); smp();
      check($sformatf("t2_done_%0d", k),  128'(req_done), 128'(e_oh));
    end

    // ---------------- Test 3: read with waitrequest stall ----------------
    nxt();
    set_req(1, 1'b0, 14'h002, 32'h0, 4'hF);
    req_valid   = 2'b10;
    avl_waitreq = 1'b1;
    smp();
    check("t3_ready", 128'(req_ready), 128'(2'b10));
    for (int c = 1; c <= 6; c++) begin
      nxt();
      req_valid   = 2'b00;
      avl_waitreq = (c < 6);
      smp();
      check($sformatf("t3_rd_hold_c%0d", c),
            128'({avl_read, avl_write, avl_address, avl_wdata}),
            128'({1'b1, 1'b0, 14'h002, 32'h0}));
    end
    avl_waitreq = 1'b0;
    for (int c = 7; c <= 8; c++) begin
      nxt(); smp();
      check($sformatf("t3_wait_c%0d", c), 128'({avl_read, req_done}), 128'(3'b000));
    end
    nxt(); avl_rdv = 1'b1; avl_rdata = 32'hDEAD_BEEF;
    smp();
    nxt(); avl_rdv = 1'b0; avl_rdata = 32'h0;
    smp();
    check("t3_done",  128'(req_done), 128'(2'b10));
    check("t3_rdata", 128'(rdata), 128'(32'hDEAD_BEEF));
    check("t3_err",   128'(req_err), 128'(2'b00));
    nxt(); smp();
    check("t3_rdata_hold", 128'(rdata), 128'(32'hDEAD_BEEF));
    check("t3_done_clr",   128'(req_done), 128'(2'b00));

    // ---------------- Test 4: read timeout, then write, stray rdv ----------------
    nxt();
    set_req(0, 1'b0, 14'h003, 32'h0, 4'hF);
    req_valid = 2'b01;
    smp();
    check("t4_ready", 128'(req_ready), 128'(2'b01));
    nxt(); req_valid = 2'b00;
    smp();
    check("t4_read", 128'(avl_read), 128'(1'b1));
    for (int c = 2; c <= 17; c++) begin
      nxt(); smp();
      check($sformatf("t4_noerr_c%0d", c), 128'({req_err, req_done}), 128'(4'b0000));
    end
    nxt(); smp();
    check("t4_err",  128'(req_err), 128'(2'b01));
    check("t4_done", 128'(req_done), 128'(2'b00));
    check("t4_rdata_keep", 128'(rdata), 128'(32'hDEAD_BEEF));
    nxt();
    set_req(1, 1'b1, 14'h004, 32'h0000_0055, 4'hF);
    req_valid = 2'b10;
    smp();
    check("t4_idle_ready", 128'(req_ready), 128'(2'b10));
    check("t4_err_clr",    128'(req_err), 128'(2'b00));
    nxt(); req_valid = 2'b00; avl_rdv = 1'b1; avl_rdata = 32'h1234_5678;
    smp();
    check("t4_wr_issue", 128'({avl_write, avl_wdata}), 128'({1'b1, 32'h0000_0055}));
    nxt(); smp();
    check("t4_wr_done", 128'(req_done), 128'(2'b10));
    check("t4_stray_rdata", 128'(rdata), 128'(32'hDEAD_BEEF));
    nxt(); avl_rdv = 1'b0; avl_rdata = 32'h0;
    smp();
    check("t4_stray_rdata2", 128'(rdata), 128'(32'hDEAD_BEEF));

    // ---------------- Test 5: reset inside WAIT_RD ----------------
    nxt();
    set_req(0, 1'b0, 14'h005, 32'h0, 4'hF);
    req_valid = 2'b01;
    smp();
    check("t5_ready", 128'(req_ready), 128'(2'b01));
    nxt(); req_valid = 2'b00;          // cycle 1 ISSUE
    nxt();                             // cycle 2 WAIT_RD
    nxt(); rst = 1'b1;                 // cycle 3 WAIT_RD, reset sampled at end
    nxt();                             // cycle 4
    smp();
    check("t5_reset_outs", all_outs(), 128'd0);
    nxt(); rst = 1'b0;
    set_req(0, 1'b1, 14'h006, 32'h0000_0066, 4'h3);
    set_req(1, 1'b1, 14'h007, 32'h0000_0077, 4'hC);
    req_valid = 2'b11;
    smp();
    check("t5_first_grant", 128'(req_ready), 128'(2'b01));
    check("t5_no_pulse",    128'({req_done, req_err}), 128'(4'b0000));
    nxt(); req_valid = 2'b00;
    smp();
    check("t5_wr_issue", 128'({avl_address, avl_be}), 128'({14'h006, 4'h3}));
    nxt(); smp();
    check("t5_done", 128'(req_done), 128'(2'b01));

    // ---------------- Test 6: readdatavalid on the timeout edge ----------------
    nxt();
    set_req(0, 1'b0, 14'h008, 32'h0, 4'hF);
    req_valid = 2'b01;
    smp();
    check("t6_ready", 128'(req_ready), 128'(2'b01));
    nxt(); req_valid = 2'b00;          // cycle 1 ISSUE
    for (int c = 2; c <= 16; c++) nxt();
    nxt(); avl_rdv = 1'b1; avl_rdata = 32'hCAFE_F00D;   // cycle 17, last timer value
    smp();
    check("t6_no_early_err", 128'(req_err), 128'(2'b00));
    nxt(); avl_rdv = 1'b0; avl_rdata = 32'h0;
    smp();
    check("t6_done",  128'(req_done), 128'(2'b01));
    check("t6_err",   128'(req_err), 128'(2'b00));
    check("t6_rdata", 128'(rdata), 128'(32'hCAFE_F00D));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
